// File: rtl/unscrambler.sv
// unscrambler: player-side inverse of the scrambler.
// Latches the scrambled permutation on load. Player swap commands then
// exchange slot contents until identity order is restored (SOLVED) or the
// mode-selected move budget runs out (FAIL).
module unscrambler #(
  parameter int BUDGET0 = 4,
  parameter int BUDGET1 = 6,
  parameter int BUDGET2 = 8,
  parameter int BUDGET3 = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] idx1,
  input  logic [2:0] idx2,
  input  logic [2:0] idx3,
  input  logic [2:0] idx4,
  input  logic [2:0] idx5,
  input  logic [2:0] idx6,
  input  logic [1:0] mode,
  input  logic       change,
  input  logic [2:0] PI1,
  input  logic [2:0] PI2,
  output logic [2:0] pos1,
  output logic [2:0] pos2,
  output logic [2:0] pos3,
  output logic [2:0] pos4,
  output logic [2:0] pos5,
  output logic [2:0] pos6,
  output logic [3:0] moves,
  output logic       busy,
  output logic       solved,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK,
    S_SOLVED,
    S_FAIL
  } state_t;

  state_t     state;
  logic [2:0] pos [6];
  logic [2:0] idx [6];
  logic [3:0] budget;
  logic [3:0] budget_sel;
  logic       change_q;
  logic       swap_req;
  logic       swap_ok;
  logic [2:0] pos_a;
  logic [2:0] pos_b;
  logic [5:0] ident;
  logic       is_identity;

  assign idx[0] = idx1;
  assign idx[1] = idx2;
  assign idx[2] = idx3;
  assign idx[3] = idx4;
  assign idx[4] = idx5;
  assign idx[5] = idx6;

  assign pos1 = pos[0];
  assign pos2 = pos[1];
  assign pos3 = pos[2];
  assign pos4 = pos[3];
  assign pos5 = pos[4];
  assign pos6 = pos[5];

  // A swap is requested only on the rising edge of the player button
  assign swap_req = change & ~change_q;

  // Both slot numbers must be valid and distinct for a swap to count
  assign swap_ok = (PI1 <= 3'd5) && (PI2 <= 3'd5) && (PI1 != PI2);

  // Slot k is in place when it holds letter k
  for (genvar gi = 0; gi < 6; gi++) begin : g_ident
    assign ident[gi] = (pos[gi] == 3'(gi));
  end
  assign is_identity = &ident;

  // Contents of the two addressed slots; zero when the slot number is invalid
  always_comb begin
    pos_a = '0;
    pos_b = '0;
    for (int k = 0; k < 6; k++) begin
      if (PI1 == 3'(k)) pos_a = pos[k];
      if (PI2 == 3'(k)) pos_b = pos[k];
    end
  end

  // Budget lookup for the difficulty presented with load
  always_comb begin
    case (mode)
      2'b00:   budget_sel = 4'(BUDGET0);
      2'b01:   budget_sel = 4'(BUDGET1);
      2'b10:   budget_sel = 4'(BUDGET2);
      default: budget_sel = 4'(BUDGET3);
    endcase
  end

  // Delayed copy of the button for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) change_q <= 1'b0;
    else     change_q <= change;
  end

  // Game FSM: latches the permutation, applies swaps, judges the result;
  // status outputs are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      for (int k = 0; k < 6; k++) pos[k] <= 3'(k);
      moves  <= '0;
      budget <= 4'(BUDGET0);
      busy   <= 1'b0;
      solved <= 1'b0;
      fail   <= 1'b0;
    end else if (load) begin
      // load wins over any simultaneous swap and works from every state
      for (int k = 0; k < 6; k++) pos[k] <= idx[k];
      budget <= budget_sel;
      moves  <= '0;
      state  <= S_CHECK;
      busy   <= 1'b1;
      solved <= 1'b0;
      fail   <= 1'b0;
    end else begin
      case (state)
        S_PLAY: begin
          if (swap_req && swap_ok) begin
            for (int k = 0; k < 6; k++) begin
              if (PI1 == 3'(k))      pos[k] <= pos_b;
              else if (PI2 == 3'(k)) pos[k] <= pos_a;
            end
            if (moves != 4'd15) moves <= moves + 4'd1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // one-cycle judgement; button edges here are dropped
          if (is_identity) begin
            state  <= S_SOLVED;
            busy   <= 1'b0;
            solved <= 1'b1;
          end else if (moves >= budget) begin
            state <= S_FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else begin
            state <= S_PLAY;
          end
        end
        default: begin
          // IDLE, SOLVED and FAIL hold everything until the next load
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: doc/unscrambler.md
Name: unscrambler

Overview:
- Player-side inverse of the scrambler: latches the six permutation indices produced when a scramble completes, then applies player swap commands (PI1/PI2 on each change press) to restore identity order.
- Counts moves against a mode-selected budget; flags solved or failed.
- Sits beside the handler. Its pos outputs drive letter selection from the ROM word; solved/fail feed the isCorrect path.

Parameters:
- BUDGET0, 4, move budget for mode 2'b00
- BUDGET1, 6, move budget for mode 2'b01
- BUDGET2, 8, move budget for mode 2'b10
- BUDGET3, 12, move budget for mode 2'b11

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- load  input  1  one-cycle pulse (scrambler_done); latch idx1..idx6 and mode
- idx1..idx6  input  3 each  scrambled permutation; slot k shows letter idx_k (0..5)
- mode  input  2  difficulty; sampled only on load
- change  input  1  synchronized player button; a swap is requested on its rising edge
- PI1, PI2  input  3 each  slot numbers (0..5) to swap
- pos1..pos6  output  3 each  current letter index in each slot
- moves  output  4  accepted swaps since load, saturates at 15
- busy  output  1  high in PLAY and CHECK
- solved  output  1  high in SOLVED
- fail  output  1  high in FAIL

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pos_k=k-1 (identity); moves=0; busy=solved=fail=0
  - change edge-detect register cleared; budget=BUDGET0
- Change edge detect: a registered copy of change; swap_req = change & ~change_q.
- IDLE:
  - swap_req ignored
  - load -> latch pos_k<=idx_k, budget<=BUDGET[mode], moves<=0, go CHECK
- PLAY, on swap_req:
  - Accepted only if PI1<=5, PI2<=5 and PI1!=PI2.
  - Accepted: pos[PI1]<=pos[PI2] and pos[PI2]<=pos[PI1] in the same edge; moves<=moves+1 (saturating); go CHECK.
  - Rejected (PI>5, or PI1==PI2): no change to pos or moves; stay PLAY.
- CHECK (exactly one cycle):
  - all pos_k==k-1 -> SOLVED
  - else moves>=budget -> FAIL
  - else -> PLAY
  - A swap_req arriving during CHECK is dropped.
- Latency: swap accepted at edge N; pos and moves updated at N; solved or fail visible at edge N+1.
- SOLVED and FAIL: hold pos and moves; ignore swap_req; exit only by load.
- load in any state (including mid-PLAY and CHECK):
  - re-latches idx, mode and budget, clears moves, goes CHECK
  - load takes priority over a simultaneous swap_req
- Loaded identity permutation -> CHECK -> SOLVED with moves=0.
- Duplicate or out-of-range idx values are not validated; CHECK simply never sees identity, so the block reaches FAIL once the budget is exhausted.
- Moves compare: zero-extended 4-bit against budget (budget ≤ 15).

Test Plan:
- Reset, then load idx=(1,0,2,3,4,5), mode=0; change with PI1=0, PI2=1 -> pos=(0,1,2,3,4,5), moves=1, solved=1 exactly one cycle after the swap edge; fail=0.
- Load identity (0,1,2,3,4,5) -> solved=1 two cycles after load, moves=0, busy low after.
- Load (5,4,3,2,1,0), mode=0; four swaps (0,1) -> moves=4, pos unchanged from the load value, fail=1; a fifth change press ignored, moves stays 4.
- In PLAY, press change with PI1=6,PI2=0, then PI1=2,PI2=2 -> pos and moves unchanged, state remains PLAY.
- Hold change high for 10 cycles with PI1=0,PI2=1 -> exactly one swap, moves=1.
- Mid-PLAY, assert rst asynchronously -> outputs immediately return to identity, moves=0, busy=0. Separately: load coincident with a change edge -> new idx latched, moves=0, no swap applied.
